// File: rtl/irq_ctrl.sv
// irq_ctrl - edge-triggered interrupt controller for the MIO bus.
//
// Rising edges on up to eight source lines become sticky pending bits. Pending
// bits are gated by a software mask to form a level INT and a priority-encoded
// source ID (bit 0 highest). A second edge on a still-pending source latches a
// sticky overflow bit.
//
// Optional build macro: IRQ_CTRL_SYNC_EN. When defined, each source passes
// through a 2-flop synchronizer (reset to 1), and edge-to-INT latency is 3
// cycles. When undefined, sources are used directly (1 cycle) and must already
// be synchronous to clk.
//
// Ports:
//   clk        peripheral clock (IO_clk)
//   rst        asynchronous active-high reset
//   irq_src    raw source lines [N_SRC-1:0]
//   reg_we     register write strobe
//   reg_addr   word index: 0 PEND (W1C), 1 MASK, 2 ID (RO), 3 SET / RAW
//   reg_wdata  write data
//   reg_rdata  combinational read data for reg_addr
//   INT        level interrupt to the CPU
//   irq_id     lowest active source index, 0 while INT is low

// Per-source cell: optional synchronizer, edge detect, pending and overflow.
module irq_ctrl_cell (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic set_sw,
  input  logic clr_pend,
  input  logic clr_ovf,
  output logic s,
  output logic pend,
  output logic ovf
);
`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync;
  // Reset to 1 so a line already high at reset release is not seen as an edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], raw};
  assign s = sync[1];
`else
  assign s = raw;
`endif

  logic prev;
  logic set;

  assign set = (s & ~prev) | set_sw;

  // Set beats a same-cycle clear. Overflow only counts when the existing pending
  // bit survives the cycle; a same-cycle W1C consumes it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= 1'b1;
      pend <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      prev <= s;
      pend <= (pend & ~clr_pend) | set;
      ovf  <= (ovf & ~clr_ovf) | (set & pend & ~clr_pend);
    end
endmodule

module irq_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              INT,
  output logic [2:0]        irq_id
);
  localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_ID = 2'd2, A_SET = 2'd3;

  logic [N_SRC-1:0] s, pend, ovf, mask, act;
  logic [N_SRC-1:0] set_sw, clr_pend, clr_ovf;
  logic             we_pend, we_mask, we_set;
  logic             unused_wdata;

  assign we_pend  = reg_we && (reg_addr == A_PEND);
  assign we_mask  = reg_we && (reg_addr == A_MASK);
  assign we_set   = reg_we && (reg_addr == A_SET);

  assign clr_pend = we_pend ? reg_wdata[N_SRC-1:0]   : '0;
  assign clr_ovf  = we_pend ? reg_wdata[8 +: N_SRC]  : '0;
  assign set_sw   = we_set  ? reg_wdata[N_SRC-1:0]   : '0;

  // Bits outside the implemented sources are deliberately ignored.
  assign unused_wdata = ^reg_wdata;

  irq_ctrl_cell u_cell [N_SRC-1:0] (
    .clk      (clk),
    .rst      (rst),
    .raw      (irq_src),
    .set_sw   (set_sw),
    .clr_pend (clr_pend),
    .clr_ovf  (clr_ovf),
    .s        (s),
    .pend     (pend),
    .ovf      (ovf)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst)          mask <= '0;
    else if (we_mask) mask <= reg_wdata[N_SRC-1:0];

  assign act = pend & mask;
  assign INT = |act;

  // Scan from the top down so the lowest active index wins.
  always_comb begin
    irq_id = 3'd0;
    for (int i = N_SRC-1; i >= 0; i--)
      if (act[i]) irq_id = 3'(i);
  end

  // Zero-extend the per-source vectors to the 8-bit register fields.
  logic [7:0] pend8, ovf8, mask8, s8;
  always_comb begin
    pend8 = '0; ovf8 = '0; mask8 = '0; s8 = '0;
    pend8[N_SRC-1:0] = pend;
    ovf8[N_SRC-1:0]  = ovf;
    mask8[N_SRC-1:0] = mask;
    s8[N_SRC-1:0]    = s;
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      A_PEND:  reg_rdata = {16'b0, ovf8, pend8};
      A_MASK:  reg_rdata = {24'b0, mask8};
      A_ID:    reg_rdata = {INT, 28'b0, irq_id};
      default: reg_rdata = {24'b0, s8};
    endcase
  end
endmodule
